mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, 2, SRAM strobe cycles per access; legal range 1..15.
REQ-002 Parameter ADDR_WIDTH, 20, SRAM word-address width.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port IFReq/IFAddress  in  1/32  instruction-fetch request level and byte address.
REQ-006 Port IFData/IFReady  out  32/1  fetched word and one-cycle completion pulse.
REQ-007 Port MemReq/MemWrite/MemByte  in  1/1/1  data request level, 1=store, 1=byte access.
REQ-008 Port MemAddress/MemWriteData  in  32/32  data byte address and store data.
REQ-009 Port MemReadData/MemReady  out  32/1  load result and one-cycle completion pulse.
REQ-010 Port StallReq  out  1  pipeline stall request.
REQ-011 Port RAMAddress  out  ADDR_WIDTH  word address = selected address[ADDR_WIDTH+1:2].
REQ-012 Port RAMDataOut/RAMDataIn/RAMDataOE  out/in/out  32/32/1  SRAM write data, read data, drive enable.
REQ-013 Port RAMCE_n/RAMOE_n/RAMWE_n/RAMBE_n  out  1/1/1/4  active-low SRAM strobes and byte enables.

Function
REQ-014 FSM states IDLE, ACCESS, DONE; 4-bit wait counter; 1-bit LastGrantMem flag.
REQ-015 IDLE: if any request, grant and go to ACCESS, counter loaded with WAIT_CYCLES-1; else stay.
REQ-016 Arbitration: only MemReq -> MEM; only IFReq -> IF; both -> IF if LastGrantMem=1, else MEM.
REQ-017 LastGrantMem updated at every grant (1 for MEM, 0 for IF).
REQ-018 Grant, address, write data, MemWrite, MemByte and address[1:0] registered at grant; inputs ignored until next IDLE.
REQ-019 ACCESS: RAMCE_n=0; read -> RAMOE_n=0; write -> RAMWE_n=0 and RAMDataOE=1; counter decrements each cycle; at counter=0 go to DONE.
REQ-020 Read data sampled from RAMDataIn on the last ACCESS cycle edge.
REQ-021 DONE lasts one cycle: granted Ready=1, returned data valid, all strobes high, then IDLE.
REQ-022 Latency: request seen in IDLE at edge N -> Ready high during cycle N+WAIT_CYCLES+1.
REQ-023 Word access: RAMBE_n=4'b0000; read data returned unmodified.
REQ-024 Byte read: RAMBE_n=4'b0000; byte address[1:0] (0 = bits 7:0) placed in MemReadData[7:0], bits 31:8 zero.
REQ-025 Byte write: MemWriteData[7:0] replicated to all four lanes; RAMBE_n low only at lane address[1:0].
REQ-026 IF access always word read; IFReady/IFData independent of MEM path.
REQ-027 StallReq = (IFReq & ~IFReady) | (MemReq & ~MemReady), combinational.
REQ-028 Request dropped mid-access: access still completes, Ready still pulses; requester ignores it.
REQ-029 Request held through DONE and IDLE is re-arbitrated as a new access.
REQ-030 IFData/MemReadData hold last returned value until next completion for that requester.
REQ-031 Outside ACCESS: RAMCE_n=RAMOE_n=RAMWE_n=1, RAMBE_n=4'b1111, RAMDataOE=0.

Reset
REQ-032 reset=1 forces asynchronously: state IDLE, counter 0, LastGrantMem 0, all strobes high, RAMBE_n=4'b1111, RAMDataOE=0.
REQ-033 Reset values: IFReady=MemReady=0, IFData=MemReadData=0, RAMAddress=0, RAMDataOut=0.
REQ-034 Reset during ACCESS aborts access immediately; no Ready pulse issued.
REQ-035 First grant after reset release occurs on first rising edge with reset=0 and a request present.

Verification
REQ-036 WAIT_CYCLES=2, IFReq, IFAddress=0x100, RAM word 0x40=0x3C010001 -> RAMAddress=0x40, OE_n low 2 cycles, IFReady cycle 3, IFData=0x3C010001.
REQ-037 IFReq and MemReq (load, 0x200) together after reset -> MEM first, IF next; both held again -> IF then MEM alternation.
REQ-038 Byte store 0xAB to 0x203 -> RAMDataOut=0xABABABAB, RAMBE_n=4'b0111, WE_n low 2 cycles, MemReady pulse.
REQ-039 Byte load 0x201, RAM word 0x11223344 -> MemReadData=0x00000033; word load -> 0x11223344.
REQ-040 reset asserted mid-ACCESS -> strobes high same cycle, no Ready; after release pending request completes normally.
REQ-041 StallReq high from request until Ready cycle, low after; dropped request -> Ready still pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester SRAM arbiter: instruction fetch and data port share one
// asynchronous SRAM through a fixed-length strobe sequence.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IFReq,
    input  logic [31:0]           IFAddress,
    output logic [31:0]           IFData,
    output logic                  IFReady,
    input  logic                  MemReq,
    input  logic                  MemWrite,
    input  logic                  MemByte,
    input  logic [31:0]           MemAddress,
    input  logic [31:0]           MemWriteData,
    output logic [31:0]           MemReadData,
    output logic                  MemReady,
    output logic                  StallReq,
    output logic [ADDR_WIDTH-1:0] RAMAddress,
    output logic [31:0]           RAMDataOut,
    input  logic [31:0]           RAMDataIn,
    output logic                  RAMDataOE,
    output logic                  RAMCE_n,
    output logic                  RAMOE_n,
    output logic                  RAMWE_n,
    output logic [3:0]            RAMBE_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    last_mem_q, last_mem_d;
    logic                    grant_mem_q, grant_mem_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              lo_q, lo_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    byte_q, byte_d;
    logic [31:0]             if_data_q, if_data_d;
    logic [31:0]             mem_data_q, mem_data_d;

    logic                    sel_mem;
    logic [31:0]             sel_addr;
    logic [7:0]              lane;
    logic                    in_access;
    logic                    unused_addr_bits;

    assign sel_mem  = MemReq & (~IFReq | ~last_mem_q);
    assign sel_addr = sel_mem ? MemAddress : IFAddress;
    assign unused_addr_bits = ^sel_addr[31:ADDR_WIDTH+2];

    always_comb begin
        lane = RAMDataIn[7:0];
        case (lo_q)
            2'd1:    lane = RAMDataIn[15:8];
            2'd2:    lane = RAMDataIn[23:16];
            2'd3:    lane = RAMDataIn[31:24];
            default: lane = RAMDataIn[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_mem_d  = last_mem_q;
        grant_mem_d = grant_mem_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        byte_d      = byte_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            IDLE: begin
                if (IFReq | MemReq) begin
                    state_d     = ACCESS;
                    cnt_d       = 4'(WAIT_CYCLES - 1);
                    last_mem_d  = sel_mem;
                    grant_mem_d = sel_mem;
                    addr_d      = sel_addr[ADDR_WIDTH+1:2];
                    lo_d        = sel_addr[1:0];
                    write_d     = sel_mem & MemWrite;
                    byte_d      = sel_mem & MemByte;
                    if (sel_mem) begin
                        wdata_d = MemByte ? {4{MemWriteData[7:0]}}
                                          : MemWriteData;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    // Read data is captured while OE_n is still asserted.
                    if (!write_q) begin
                        if (grant_mem_q) begin
                            mem_data_d = byte_q ? {24'h0, lane} : RAMDataIn;
                        end else begin
                            if_data_d = RAMDataIn;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_mem_q  <= 1'b0;
            grant_mem_q <= 1'b0;
            addr_q      <= '0;
            lo_q        <= 2'd0;
            wdata_q     <= 32'h0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            if_data_q   <= 32'h0;
            mem_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_mem_q  <= last_mem_d;
            grant_mem_q <= grant_mem_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign in_access  = (state_q == ACCESS);
    assign RAMCE_n    = ~in_access;
    assign RAMOE_n    = ~(in_access & ~write_q);
    assign RAMWE_n    = ~(in_access & write_q);
    assign RAMDataOE  = in_access & write_q;
    assign RAMBE_n    = !in_access ? 4'b1111 :
                        (write_q & byte_q) ? ~(4'b0001 << lo_q) : 4'b0000;
    assign RAMAddress = addr_q;
    assign RAMDataOut = wdata_q;

    assign IFReady     = (state_q == DONE) & ~grant_mem_q;
    assign MemReady    = (state_q == DONE) & grant_mem_q;
    assign IFData      = if_data_q;
    assign MemReadData = mem_data_q;
    assign StallReq    = (IFReq & ~IFReady) | (MemReq & ~MemReady);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural SRAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFReq, MemReq, MemWrite, MemByte;
    logic [31:0] IFAddress, MemAddress, MemWriteData;
    logic [31:0] IFData, MemReadData, RAMDataOut, RAMDataIn;
    logic        IFReady, MemReady, StallReq, RAMDataOE;
    logic        RAMCE_n, RAMOE_n, RAMWE_n;
    logic [3:0]  RAMBE_n;
    logic [19:0] RAMAddress;

    logic [31:0] ram [0:255];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(2), .ADDR_WIDTH(20)) dut (
        .clk(clk), .reset(reset),
        .IFReq(IFReq), .IFAddress(IFAddress),
        .IFData(IFData), .IFReady(IFReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemByte(MemByte),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData), .MemReady(MemReady),
        .StallReq(StallReq), .RAMAddress(RAMAddress),
        .RAMDataOut(RAMDataOut), .RAMDataIn(RAMDataIn),
        .RAMDataOE(RAMDataOE), .RAMCE_n(RAMCE_n), .RAMOE_n(RAMOE_n),
        .RAMWE_n(RAMWE_n), .RAMBE_n(RAMBE_n)
    );

    assign RAMDataIn = ram[RAMAddress[7:0]];

    always @(posedge clk) begin
        if (!RAMCE_n && !RAMWE_n) begin
            for (int i = 0; i < 4; i++) begin
                if (!RAMBE_n[i])
                    ram[RAMAddress[7:0]][8*i +: 8] <= RAMDataOut[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(output int n, output logic got_if,
                        output logic got_mem, output int oe_lo,
                        output int we_lo, output logic [3:0] be,
                        output logic [31:0] dout, output logic [19:0] addr);
        n = 0; oe_lo = 0; we_lo = 0; got_if = 0; got_mem = 0;
        be = 4'hf; dout = 0; addr = 0;
        while (n < 20 && !got_if && !got_mem) begin
            @(negedge clk);
            n++;
            if (!RAMOE_n) oe_lo++;
            if (!RAMWE_n) we_lo++;
            if (!RAMCE_n) begin
                be = RAMBE_n; dout = RAMDataOut; addr = RAMAddress;
            end
            got_if = IFReady;
            got_mem = MemReady;
        end
        if (!got_if && !got_mem) check("ready_timeout", 0, 1);
    endtask

    task automatic idle();
        IFReq = 0; MemReq = 0; MemWrite = 0; MemByte = 0;
        @(negedge clk);
    endtask

    int n, oe_lo, we_lo, pulses, ce_cnt;
    logic gi, gm;
    logic [3:0] be;
    logic [31:0] dout;
    logic [19:0] addr;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h40] = 32'h3C010001;
        ram[8'h41] = 32'hCAFEF00D;
        ram[8'h80] = 32'h11223344;
        reset = 1; IFReq = 0; MemReq = 0; MemWrite = 0; MemByte = 0;
        IFAddress = 0; MemAddress = 0; MemWriteData = 0;
        repeat (2) @(negedge clk);

        check("rst_ifready", {31'h0, IFReady}, 0);
        check("rst_memready", {31'h0, MemReady}, 0);
        check("rst_ifdata", IFData, 0);
        check("rst_memdata", MemReadData, 0);
        check("rst_ramaddr", {12'h0, RAMAddress}, 0);
        check("rst_dout", RAMDataOut, 0);
        check("rst_strobes", {29'h0, RAMCE_n, RAMOE_n, RAMWE_n}, 3'b111);
        check("rst_be", {28'h0, RAMBE_n}, 4'hf);
        check("rst_oe", {31'h0, RAMDataOE}, 0);

        reset = 0; IFReq = 1; IFAddress = 32'h100;
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("if_latency", n, 3);
        check("if_grant", {30'h0, gi, gm}, 2'b10);
        check("if_oe_cycles", oe_lo, 2);
        check("if_we_cycles", we_lo, 0);
        check("if_ramaddr", {12'h0, addr}, 32'h40);
        check("if_data", IFData, 32'h3C010001);
        check("if_done_ce", {31'h0, RAMCE_n}, 1);
        check("if_done_stall", {31'h0, StallReq}, 0);
        idle();
        check("if_ready_pulse", {31'h0, IFReady}, 0);
        check("if_data_hold", IFData, 32'h3C010001);

        reset = 1; @(negedge clk); reset = 0;
        IFReq = 1; IFAddress = 32'h104;
        MemReq = 1; MemAddress = 32'h200;
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("arb1_grant", {30'h0, gi, gm}, 2'b01);
        check("arb1_latency", n, 3);
        check("word_load", MemReadData, 32'h11223344);
        check("word_load_be", {28'h0, be}, 4'h0);
        check("arb1_stall_if", {31'h0, StallReq}, 1);
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("arb2_grant", {30'h0, gi, gm}, 2'b10);
        check("arb2_latency", n, 4);
        check("arb2_ifdata", IFData, 32'hCAFEF00D);
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("arb3_grant", {30'h0, gi, gm}, 2'b01);
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("arb4_grant", {30'h0, gi, gm}, 2'b10);
        idle();

        MemReq = 1; MemByte = 1; MemAddress = 32'h201;
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("bload_data", MemReadData, 32'h00000033);
        check("bload_be", {28'h0, be}, 4'h0);
        idle();

        MemReq = 1; MemWrite = 1; MemByte = 1;
        MemAddress = 32'h203; MemWriteData = 32'h123456AB;
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("bstore_grant", {30'h0, gi, gm}, 2'b01);
        check("bstore_dout", dout, 32'hABABABAB);
        check("bstore_be", {28'h0, be}, 4'b0111);
        check("bstore_we_cycles", we_lo, 2);
        check("bstore_oe_cycles", oe_lo, 0);
        check("bstore_data_hold", MemReadData, 32'h00000033);
        idle();
        check("bstore_ram", ram[8'h80], 32'hAB223344);

        MemReq = 1; MemWrite = 0; MemByte = 1; MemAddress = 32'h203;
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("bload_lane3", MemReadData, 32'h000000AB);
        idle();

        MemReq = 1; MemByte = 0; MemAddress = 32'h200;
        @(negedge clk);
        check("abort_in_access", {31'h0, RAMCE_n}, 0);
        #2 reset = 1;
        #1;
        check("abort_strobes", {29'h0, RAMCE_n, RAMOE_n, RAMWE_n}, 3'b111);
        check("abort_be", {28'h0, RAMBE_n}, 4'hf);
        @(negedge clk);
        check("abort_no_ready", {30'h0, IFReady, MemReady}, 0);
        reset = 0;
        step(n, gi, gm, oe_lo, we_lo, be, dout, addr);
        check("abort_retry_lat", n, 3);
        check("abort_retry_data", MemReadData, 32'hAB223344);
        idle();

        IFReq = 1; IFAddress = 32'h104;
        @(negedge clk);
        IFReq = 0;
        #1;
        check("drop_stall", {31'h0, StallReq}, 0);
        pulses = 0; ce_cnt = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (IFReady) pulses++;
            if (!RAMCE_n) ce_cnt++;
        end
        check("drop_pulses", pulses, 1);
        check("drop_ce_cycles", ce_cnt, 2);
        check("drop_ifdata", IFData, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
